// File: rtl/lcd_pkg.sv
// Shared types and constants for the KS0108 page arbiter.
// Holds the arbiter state enum, the LCD command encodings, the chip-select
// codes and two small helpers that build the set-page command and the chip select.
package lcd_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StCmdX,
    StCmdY,
    StData,
    StDone
  } state_e;

  localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;
  localparam logic [7:0] CMD_SET_Y0     = 8'h40;
  localparam logic [4:0] CMD_SET_X_BASE = 5'b10111;

  localparam logic [1:0] CS_LEFT  = 2'b01;
  localparam logic [1:0] CS_RIGHT = 2'b10;
  localparam logic [1:0] CS_BOTH  = 2'b11;

  function automatic logic [7:0] cmd_set_x(input logic [2:0] page);
    return {CMD_SET_X_BASE, page};
  endfunction

  function automatic logic [1:0] chip_cs(input logic chip);
    return chip ? CS_RIGHT : CS_LEFT;
  endfunction

endpackage

// File: rtl/lcd_bus_wr.sv
// Single KS0108 bus write engine.
// A start while idle latches di/data/cs, then holds LCD_en high for EN_HALF
// cycles and low for EN_HALF cycles; the panel latches on the falling edge.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, di, data, cs write request and its bus values
//   lcd_en/di/data/cs   registered LCD pins
//   idle                a new start is accepted this cycle
//   done_strobe         last cycle of the low phase of the current write
module lcd_bus_wr #(
  parameter int unsigned EN_HALF = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       di,
  input  logic [7:0] data,
  input  logic [1:0] cs,
  output logic       lcd_en,
  output logic       lcd_di,
  output logic [7:0] lcd_data,
  output logic [1:0] lcd_cs,
  output logic       idle,
  output logic       done_strobe
);

  typedef enum logic [1:0] {PhIdle, PhHigh, PhLow} phase_e;

  localparam logic [7:0] CntMax = 8'(EN_HALF - 1);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_q, en_d;
  logic       di_q, di_d;
  logic [7:0] data_q, data_d;
  logic [1:0] cs_q, cs_d;
  logic       last_tick;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    di_d    = di_q;
    data_d  = data_q;
    cs_d    = cs_q;

    last_tick   = (cnt_q == CntMax);
    done_strobe = (phase_q == PhLow) && last_tick;
    // The final low cycle already counts as free so writes run back to back.
    idle        = (phase_q == PhIdle) || done_strobe;

    case (phase_q)
      PhHigh: begin
        if (last_tick) begin
          phase_d = PhLow;
          cnt_d   = 8'd0;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PhLow: begin
        if (last_tick) begin
          phase_d = PhIdle;
          cs_d    = 2'b00;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    if (start && idle) begin
      phase_d = PhHigh;
      cnt_d   = 8'd0;
      en_d    = 1'b1;
      di_d    = di;
      data_d  = data;
      cs_d    = cs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PhIdle;
      cnt_q   <= 8'd0;
      en_q    <= 1'b0;
      di_q    <= 1'b0;
      data_q  <= 8'h00;
      cs_q    <= 2'b00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      di_q    <= di_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
    end
  end

  assign lcd_en   = en_q;
  assign lcd_di   = di_q;
  assign lcd_data = data_q;
  assign lcd_cs   = cs_q;

endmodule

// File: rtl/lcd_page_arb.sv
// Round-robin arbiter sharing one KS0108 128x64 LCD between two page writers.
// A granted requester gets set-page and set-column commands issued for it,
// then streams COLS bytes over valid/ready; done pulses after the last write.
// Optional macro LCD_INIT_EN: after reset, write display-on, start-line-0 and
// column-0 to both chips before serving requests.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_n, page_n, chip_n               page write request and target
//   src_data_n, src_valid_n, src_ready_n byte stream handshake
//   gnt_n, done_n                       one-cycle grant / completion pulses
//   busy                                high outside IDLE
//   LCD_*                               panel pins
module lcd_page_arb
  import lcd_pkg::*;
#(
  parameter int unsigned EN_HALF = 1,
  parameter int unsigned COLS    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_0,
  input  logic       req_1,
  input  logic [2:0] page_0,
  input  logic [2:0] page_1,
  input  logic       chip_0,
  input  logic       chip_1,
  input  logic [7:0] src_data_0,
  input  logic [7:0] src_data_1,
  input  logic       src_valid_0,
  input  logic       src_valid_1,
  output logic       src_ready_0,
  output logic       src_ready_1,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       done_0,
  output logic       done_1,
  output logic       busy,
  output logic       LCD_di,
  output logic       LCD_rw,
  output logic       LCD_en,
  output logic       LCD_rst,
  output logic [1:0] LCD_cs,
  output logic [7:0] LCD_data
);

  localparam logic [5:0] LastCol = 6'(COLS - 1);
`ifdef LCD_INIT_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e     state_q, state_d;
  logic       id_q, id_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] cs_q, cs_d;
  logic [5:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
`ifdef LCD_INIT_EN
  logic [1:0] init_idx_q, init_idx_d;
`endif

  logic       wr_start, wr_di, bus_idle, bus_done;
  logic [7:0] wr_data;
  logic [1:0] wr_cs;
  logic       ready_sel, sel_valid, grant_id;
  logic [7:0] sel_data;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cs_d         = cs_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
`ifdef LCD_INIT_EN
    init_idx_d   = init_idx_q;
`endif
    wr_start     = 1'b0;
    wr_di        = 1'b0;
    wr_data      = 8'h00;
    wr_cs        = cs_q;
    ready_sel    = 1'b0;
    done_0       = 1'b0;
    done_1       = 1'b0;

    sel_valid = id_q ? src_valid_1 : src_valid_0;
    sel_data  = id_q ? src_data_1 : src_data_0;
    // On a tie the requester that did not win last time goes next.
    grant_id  = (req_0 && req_1) ? ~last_grant_q : req_1;

    case (state_q)
      StInit: begin
`ifdef LCD_INIT_EN
        if (bus_idle) begin
          if (init_idx_q == 2'd3) begin
            state_d = StIdle;
          end else begin
            wr_start   = 1'b1;
            wr_cs      = CS_BOTH;
            wr_data    = (init_idx_q == 2'd0) ? CMD_DISP_ON :
                         (init_idx_q == 2'd1) ? CMD_START_LINE : CMD_SET_Y0;
            init_idx_d = init_idx_q + 2'd1;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StIdle: begin
        // The set-page write starts straight from the grant so no bus cycle is lost.
        if ((req_0 || req_1) && bus_idle) begin
          id_d         = grant_id;
          last_grant_d = grant_id;
          gnt0_d       = ~grant_id;
          gnt1_d       = grant_id;
          cs_d         = chip_cs(grant_id ? chip_1 : chip_0);
          wr_start     = 1'b1;
          wr_cs        = cs_d;
          wr_data      = cmd_set_x(grant_id ? page_1 : page_0);
          state_d      = StCmdX;
        end
      end
      StCmdX: begin
        if (bus_idle) begin
          wr_start = 1'b1;
          wr_data  = CMD_SET_Y0;
          state_d  = StCmdY;
        end
      end
      StCmdY: state_d = StData;
      StData: begin
        ready_sel = bus_idle && !last_q;
        if (ready_sel && sel_valid) begin
          wr_start = 1'b1;
          wr_di    = 1'b1;
          wr_data  = sel_data;
          // Hold at the last column; the count only wraps when leaving DONE.
          if (cnt_q == LastCol) last_d = 1'b1;
          else                  cnt_d  = cnt_q + 6'd1;
        end
        if (last_q && bus_done) state_d = StDone;
      end
      StDone: begin
        done_0  = ~id_q;
        done_1  = id_q;
        cnt_d   = 6'd0;
        last_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ResetState;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cs_q         <= 2'b00;
      cnt_q        <= 6'd0;
      last_q       <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx_q   <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cs_q         <= cs_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
`ifdef LCD_INIT_EN
      init_idx_q   <= init_idx_d;
`endif
    end
  end

  lcd_bus_wr #(
    .EN_HALF(EN_HALF)
  ) u_bus_wr (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (wr_start),
    .di         (wr_di),
    .data       (wr_data),
    .cs         (wr_cs),
    .lcd_en     (LCD_en),
    .lcd_di     (LCD_di),
    .lcd_data   (LCD_data),
    .lcd_cs     (LCD_cs),
    .idle       (bus_idle),
    .done_strobe(bus_done)
  );

  assign src_ready_0 = ready_sel && !id_q;
  assign src_ready_1 = ready_sel && id_q;
  assign gnt_0       = gnt0_q;
  assign gnt_1       = gnt1_q;
  assign busy        = (state_q != StIdle);
  assign LCD_rw      = 1'b0;
  assign LCD_rst     = rst_n;

endmodule

// File: tb/tb_lcd_page_arb.sv
module tb_lcd_page_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_0, req_1, chip_0, chip_1, src_valid_0, src_valid_1;
  logic [2:0] page_0, page_1;
  logic [7:0] src_data_0, src_data_1;
  logic       src_ready_0, src_ready_1, gnt_0, gnt_1, done_0, done_1, busy;
  logic       LCD_di, LCD_rw, LCD_en, LCD_rst;
  logic [1:0] LCD_cs;
  logic [7:0] LCD_data;

  // Second instance with EN_HALF=3, exercised through requester 1 only.
  logic       b_req_1, b_chip_1, b_src_valid_1;
  logic [2:0] b_page_1;
  logic [7:0] b_src_data_1;
  logic       b_src_ready_0, b_src_ready_1, b_gnt_0, b_gnt_1, b_done_0, b_done_1, b_busy;
  logic       b_LCD_di, b_LCD_rw, b_LCD_en, b_LCD_rst;
  logic [1:0] b_LCD_cs;
  logic [7:0] b_LCD_data;

  lcd_page_arb #(.EN_HALF(1), .COLS(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1),
    .page_0(page_0), .page_1(page_1), .chip_0(chip_0), .chip_1(chip_1),
    .src_data_0(src_data_0), .src_data_1(src_data_1),
    .src_valid_0(src_valid_0), .src_valid_1(src_valid_1),
    .src_ready_0(src_ready_0), .src_ready_1(src_ready_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1), .busy(busy),
    .LCD_di(LCD_di), .LCD_rw(LCD_rw), .LCD_en(LCD_en), .LCD_rst(LCD_rst),
    .LCD_cs(LCD_cs), .LCD_data(LCD_data)
  );

  lcd_page_arb #(.EN_HALF(3), .COLS(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_0(1'b0), .req_1(b_req_1),
    .page_0(3'd0), .page_1(b_page_1), .chip_0(1'b0), .chip_1(b_chip_1),
    .src_data_0(8'h00), .src_data_1(b_src_data_1),
    .src_valid_0(1'b0), .src_valid_1(b_src_valid_1),
    .src_ready_0(b_src_ready_0), .src_ready_1(b_src_ready_1),
    .gnt_0(b_gnt_0), .gnt_1(b_gnt_1), .done_0(b_done_0), .done_1(b_done_1), .busy(b_busy),
    .LCD_di(b_LCD_di), .LCD_rw(b_LCD_rw), .LCD_en(b_LCD_en), .LCD_rst(b_LCD_rst),
    .LCD_cs(b_LCD_cs), .LCD_data(b_LCD_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // LCD models: record {di, cs, data} at every falling edge of LCD_en.
  logic [10:0] wq[$];
  logic [10:0] wqb[$];
  int en_edges = 0, done0_cnt = 0, done1_cnt = 0;
  always @(negedge LCD_en) wq.push_back({LCD_di, LCD_cs, LCD_data});
  always @(negedge b_LCD_en) wqb.push_back({b_LCD_di, b_LCD_cs, b_LCD_data});
  always @(LCD_en) en_edges++;
  always @(negedge clk) begin
    if (done_0) done0_cnt++;
    if (done_1) done1_cnt++;
  end

  // Instance b: LCD_en high width must be 3 samples with pins stable throughout.
  int b_hi = 0, b_bad = 0;
  logic [10:0] b_hold;
  always @(negedge clk) begin
    if (b_LCD_en === 1'b1) begin
      if (b_hi == 0) b_hold = {b_LCD_di, b_LCD_cs, b_LCD_data};
      else if (b_hold !== {b_LCD_di, b_LCD_cs, b_LCD_data}) b_bad++;
      b_hi++;
    end else if (b_hi != 0) begin
      if (b_hi != 3) b_bad++;
      b_hi = 0;
    end
  end

  // Byte sources: ramp restarts on each grant; requester 0 is offset by 0x80.
  int idx0 = 0, idx1 = 0, idxb = 0;
  logic acc0, acc1, accb, g0, g1, gb;
  initial begin
    src_data_0 = 8'h80; src_data_1 = 8'h00; b_src_data_1 = 8'h00;
    forever begin
      @(negedge clk);
      acc0 = src_valid_0 && src_ready_0;
      acc1 = src_valid_1 && src_ready_1;
      accb = b_src_valid_1 && b_src_ready_1;
      g0 = gnt_0; g1 = gnt_1; gb = b_gnt_1;
      @(posedge clk);
      #1;
      if (g0) idx0 = 0; else if (acc0) idx0++;
      if (g1) idx1 = 0; else if (acc1) idx1++;
      if (gb) idxb = 0; else if (accb) idxb++;
      src_data_0   = 8'(idx0) + 8'h80;
      src_data_1   = 8'(idx1);
      b_src_data_1 = 8'(idxb);
    end
  end

  task automatic wait_gnt(output int who, output int n);
    who = -1; n = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gnt_0 || gnt_1) begin
        who = gnt_1 ? 1 : 0;
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_0 || done_1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && b_busy === 1'b0) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_q(input string tag, input logic [7:0] cmd, input logic [1:0] cs,
                         input logic [7:0] base, input bit use_b);
    int n, bad;
    logic [10:0] w, e;
    n = use_b ? wqb.size() : wq.size();
    bad = 0;
    check({tag, " writes"}, n, 66);
    w = (n > 0) ? (use_b ? wqb[0] : wq[0]) : 11'h7FF;
    check({tag, " cmd_x"}, w, {1'b0, cs, cmd});
    for (int i = 0; i < n; i++) begin
      w = use_b ? wqb[i] : wq[i];
      if (i == 0)      e = {1'b0, cs, cmd};
      else if (i == 1) e = {1'b0, cs, 8'h40};
      else             e = {1'b1, cs, base + 8'(i - 2)};
      if (i >= 66 || w !== e) bad++;
    end
    check({tag, " content"}, bad, 0);
  endtask

  typedef struct {
    logic       r0, r1;
    logic [2:0] p0, p1;
    logic       c0, c1;
    int         id;
    logic [7:0] cmd;
    logic [1:0] cs;
  } vec_t;
  vec_t vecs[5];

`ifdef LCD_INIT_EN
  localparam logic BusyRst = 1'b1;
`else
  localparam logic BusyRst = 1'b0;
`endif

  int who, n, cyc, bad, e0, d0, d1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{r0:1, r1:0, p0:3, p1:0, c0:0, c1:0, id:0, cmd:8'hBB, cs:2'b01};
    vecs[1] = '{r0:0, r1:1, p0:0, p1:5, c0:0, c1:1, id:1, cmd:8'hBD, cs:2'b10};
    vecs[2] = '{r0:1, r1:1, p0:0, p1:2, c0:1, c1:0, id:0, cmd:8'hB8, cs:2'b10};
    vecs[3] = '{r0:1, r1:1, p0:6, p1:4, c0:0, c1:1, id:1, cmd:8'hBC, cs:2'b10};
    vecs[4] = '{r0:1, r1:0, p0:7, p1:0, c0:1, c1:0, id:0, cmd:8'hBF, cs:2'b10};

    rst_n = 1'b0;
    req_0 = 0; req_1 = 0; page_0 = 0; page_1 = 0; chip_0 = 0; chip_1 = 0;
    src_valid_0 = 1; src_valid_1 = 1;
    b_req_1 = 0; b_page_1 = 0; b_chip_1 = 0; b_src_valid_1 = 1;
    repeat (3) @(negedge clk);
    check("reset outputs", {LCD_en, LCD_di, LCD_data, LCD_cs, gnt_0, gnt_1, done_0, done_1,
                            src_ready_0, src_ready_1, LCD_rw, LCD_rst}, 0);
    check("reset busy", busy, BusyRst);
    check("reset outputs b", {b_LCD_en, b_LCD_di, b_LCD_data, b_LCD_cs, b_gnt_1, b_done_1,
                              b_src_ready_1, b_LCD_rst}, 0);
    rst_n = 1'b1;

`ifdef LCD_INIT_EN
    req_0 = 1; page_0 = 0; chip_0 = 0;
    @(negedge clk);
    check("init busy", busy, 1);
    wait_gnt(who, n);
    check("init gnt id", who, 0);
    check("init writes before gnt", wq.size(), 3);
    check("init w0", (wq.size() > 0) ? wq[0] : 11'h7FF, {1'b0, 2'b11, 8'h3F});
    check("init w1", (wq.size() > 1) ? wq[1] : 11'h7FF, {1'b0, 2'b11, 8'hC0});
    check("init w2", (wq.size() > 2) ? wq[2] : 11'h7FF, {1'b0, 2'b11, 8'h40});
    req_0 = 0;
    wait_done(cyc);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif
    wait_idle();

    // Table: single and tied requests; req/page/chip are scrambled after grant.
    for (int v = 0; v < 5; v++) begin
      wq.delete();
      e0 = en_edges; d0 = done0_cnt; d1 = done1_cnt;
      req_0 = vecs[v].r0; req_1 = vecs[v].r1;
      page_0 = vecs[v].p0; page_1 = vecs[v].p1;
      chip_0 = vecs[v].c0; chip_1 = vecs[v].c1;
      wait_gnt(who, n);
      check($sformatf("v%0d gnt id", v), who, vecs[v].id);
      check($sformatf("v%0d busy", v), busy, 1);
      req_0 = 0; req_1 = 0;
      page_0 = ~page_0; page_1 = ~page_1; chip_0 = ~chip_0; chip_1 = ~chip_1;
      wait_done(cyc);
      check($sformatf("v%0d done seen", v), (cyc >= 0), 1);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d idle busy", v), busy, 0);
      check($sformatf("v%0d idle cs", v), LCD_cs, 2'b00);
      check($sformatf("v%0d done0 count", v), done0_cnt - d0, (vecs[v].id == 0) ? 1 : 0);
      check($sformatf("v%0d done1 count", v), done1_cnt - d1, (vecs[v].id == 1) ? 1 : 0);
      check($sformatf("v%0d en edges", v), en_edges - e0, 132);
      check_q($sformatf("v%0d", v), vecs[v].cmd, vecs[v].cs,
              (vecs[v].id == 0) ? 8'h80 : 8'h00, 1'b0);
    end

    // Stall requester 1 at byte 20 for 10 cycles.
    wq.delete();
    req_1 = 1; page_1 = 1; chip_1 = 0;
    wait_gnt(who, n);
    check("stall gnt id", who, 1);
    req_1 = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (idx1 == 20) break;
    end
    check("stall reached byte 20", idx1, 20);
    src_valid_1 = 0;
    bad = 0;
    repeat (2) @(negedge clk);
    repeat (8) begin
      @(negedge clk);
      if (LCD_en !== 1'b0 || src_ready_1 !== 1'b1) bad++;
    end
    check("stall en low ready high", bad, 0);
    check("stall no accept", idx1, 20);
    @(posedge clk);
    #2;
    src_valid_1 = 1;
    wait_done(cyc);
    check("stall done seen", (cyc >= 0), 1);
    repeat (2) @(negedge clk);
    check_q("stall", 8'hB9, 2'b01, 8'h00, 1'b0);

    // Tie from reset: 0 first, then 1, then 0; next grant two cycles after done.
    @(negedge clk);
    rst_n = 1'b0;
    req_0 = 1; req_1 = 1; page_0 = 1; chip_0 = 0; page_1 = 2; chip_1 = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(who, n);
    check("tie first", who, 0);
    wait_done(cyc);
    wait_gnt(who, n);
    check("tie second", who, 1);
    check("tie gap cycles", n, 2);
    wait_done(cyc);
    wait_gnt(who, n);
    check("tie third", who, 0);
    req_0 = 0; req_1 = 0;
    wait_done(cyc);
    check("tie done seen", (cyc >= 0), 1);
    repeat (3) @(negedge clk);

    // Asynchronous reset at byte 30, then a fresh request restarts at CMD_X.
    req_0 = 1; page_0 = 2; chip_0 = 1;
    wait_gnt(who, n);
    req_0 = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (idx0 == 30) break;
    end
    check("reset reached byte 30", idx0, 30);
    check("reset mid-write en high", LCD_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {LCD_en, LCD_di, LCD_data, LCD_cs, gnt_0, gnt_1, done_0,
                                  done_1, src_ready_0, src_ready_1, LCD_rst}, 0);
    check("async reset busy", busy, BusyRst);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle();
    wq.delete();
    req_0 = 1; page_0 = 2; chip_0 = 1;
    wait_gnt(who, n);
    check("restart gnt id", who, 0);
    req_0 = 0;
    wait_done(cyc);
    repeat (2) @(negedge clk);
    check_q("restart", 8'hBA, 2'b10, 8'h80, 1'b0);

    // Instance b: EN_HALF=3, right chip, page 7.
    wqb.delete();
    b_req_1 = 1; b_page_1 = 7; b_chip_1 = 1;
    cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_gnt_1) begin
        cyc = i;
        break;
      end
    end
    check("eh3 gnt seen", (cyc >= 0), 1);
    b_req_1 = 0;
    cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (b_done_1) begin
        cyc = i;
        break;
      end
    end
    check("eh3 done seen", (cyc >= 0), 1);
    repeat (4) @(negedge clk);
    check_q("eh3", 8'hBF, 2'b10, 8'h00, 1'b1);
    check("eh3 en width and stability", b_bad, 0);
    check("eh3 idle cs", b_LCD_cs, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
